// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep sequencer: FSM state encoding and
// default widths for the counter bounds and the sweep counter.
package sweep_pkg;

  localparam int SW_WIDTH = 4;  // default counter/bound width
  localparam int SW_NSW_W = 4;  // default sweep-count width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_DONE = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/sweep_cnt_core.sv
// Up/down counter datapath: load has priority over inc, inc over dec;
// with none asserted the count holds.
module sweep_cnt_core
  import sweep_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count register with synchronous reset and prioritised load/inc/dec.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (reset)     cnt <= '0;
    else if (load) cnt <= d;
    else if (inc)  cnt <= cnt + ONE;
    else if (dec)  cnt <= cnt - ONE;
  end

endmodule

// File: rtl/sweep_seq_ctrl.sv
// Triangle-sweep sequencer: latches lo/hi/nsweeps on an accepted start and
// steps the counter core lo->hi->lo nsweeps times, reporting busy/done/err.
// Optional macro SWEEP_CONT_EN: nsweeps==0 selects continuous sweeping that
// only abort ends; without it nsweeps==0 is rejected with an err pulse.
module sweep_seq_ctrl
  import sweep_pkg::*;
#(
  parameter int WIDTH = SW_WIDTH,
  parameter int NSW_W = SW_NSW_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             hold,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [NSW_W-1:0] nsweeps,
  output logic [WIDTH-1:0] cnt,
  output logic             up,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [NSW_W-1:0] sweep_idx
);

  localparam logic [NSW_W-1:0] ONE_N = NSW_W'(1);

  sweep_state_t     state, state_n;
  logic [WIDTH-1:0] lo_l, hi_l;
  logic [NSW_W-1:0] nsweeps_l;
  logic [NSW_W-1:0] idx_next;
  logic             load, inc, dec;
  logic             accept, idx_inc, err_set;
  logic             start_ok, last_sweep;

  sweep_cnt_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .inc   (inc),
    .dec   (dec),
    .d     (lo),
    .cnt   (cnt)
  );

  assign idx_next = sweep_idx + ONE_N;

`ifdef SWEEP_CONT_EN
  // Zero sweeps means run forever; sweep_idx then simply wraps.
  assign start_ok   = (lo < hi);
  assign last_sweep = (nsweeps_l != '0) && (idx_next == nsweeps_l);
`else
  assign start_ok   = (lo < hi) && (nsweeps != '0);
  assign last_sweep = (idx_next == nsweeps_l);
`endif

  assign up   = (state == ST_UP);
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // State, latched run parameters, sweep index and the err pulse register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      lo_l      <= '0;
      hi_l      <= '0;
      nsweeps_l <= '0;
      sweep_idx <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_n;
      err   <= err_set;
      if (accept) begin
        lo_l      <= lo;
        hi_l      <= hi;
        nsweeps_l <= nsweeps;
        sweep_idx <= '0;
      end else if (idx_inc) begin
        sweep_idx <= idx_next;
      end
    end
  end

  // Next-state and counter-control decode; abort outranks hold.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_n = state;
    load    = 1'b0;
    inc     = 1'b0;
    dec     = 1'b0;
    accept  = 1'b0;
    idx_inc = 1'b0;
    err_set = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (start_ok) begin
            accept  = 1'b1;
            load    = 1'b1;
            state_n = ST_UP;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      ST_UP: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (!hold) begin
          if (cnt != hi_l) begin
            inc = 1'b1;
          end else begin
            dec     = 1'b1;
            state_n = ST_DOWN;
          end
        end
      end
      ST_DOWN: begin
        if (abort) begin
          state_n = ST_IDLE;
        end else if (!hold) begin
          if (cnt != lo_l) begin
            dec = 1'b1;
          end else begin
            idx_inc = 1'b1;
            if (last_sweep) begin
              state_n = ST_DONE;
            end else begin
              inc     = 1'b1;
              state_n = ST_UP;
            end
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sweep_seq_ctrl.sv
// Directed testbench for sweep_seq_ctrl: expected values are hand-derived
// from the sweep timing (accept-to-done = 2*(hi-lo)*nsweeps + 1 cycles).
module tb_sweep_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset, start, abort, hold;
  logic [3:0] lo, hi, nsweeps;
  logic [3:0] cnt, sweep_idx;
  logic       up, busy, done, err;

  int vectors = 0;
  int miscompares = 0;

  sweep_seq_ctrl #(.WIDTH(4), .NSW_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .hold      (hold),
    .lo        (lo),
    .hi        (hi),
    .nsweeps   (nsweeps),
    .cnt       (cnt),
    .up        (up),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sweep_idx (sweep_idx)
  );

  always #5 clock = ~clock;

  // One rising edge, then settle before sampling or driving.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({cnt, up, busy, done, err, sweep_idx} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_state: got cnt=%0d up=%b busy=%b done=%b err=%b idx=%0d, want all 0",
               cnt, up, busy, done, err, sweep_idx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_sweep();
    logic [3:0] exp_cnt [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    logic       exp_up  [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    lo = 4'd2; hi = 4'd5; nsweeps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lo = 4'd0; hi = 4'd15; nsweeps = 4'd9;  // must not affect the run
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (cnt !== exp_cnt[i] || up !== exp_up[i] || done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL basic_step%0d: got cnt=%0d up=%b done=%b busy=%b, want cnt=%0d up=%b done=0 busy=1",
                 i, cnt, up, done, busy, exp_cnt[i], exp_up[i]);
      end
      tick();
    end
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1 || cnt !== 4'd2 || sweep_idx !== 4'd1) begin
      miscompares++;
      $display("FAIL basic_done: got done=%b busy=%b cnt=%0d idx=%0d, want done=1 busy=1 cnt=2 idx=1",
               done, busy, cnt, sweep_idx);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || cnt !== 4'd2) begin
      miscompares++;
      $display("FAIL basic_idle: got done=%b busy=%b cnt=%0d, want done=0 busy=0 cnt=2",
               done, busy, cnt);
    end
  endtask

  task automatic test_full_range();
    int  c    = 0;
    bit  seen = 1'b0;
    lo = 4'd0; hi = 4'd15; nsweeps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    while (!seen && c < 80) begin
      tick();
      c++;
      if (c == 15) begin
        vectors++;
        if (cnt !== 4'd15 || up !== 1'b1) begin
          miscompares++;
          $display("FAIL full_peak: got cnt=%0d up=%b, want cnt=15 up=1", cnt, up);
        end
      end
      if (c == 16) begin
        vectors++;
        if (cnt !== 4'd14 || up !== 1'b0) begin
          miscompares++;
          $display("FAIL full_turn: got cnt=%0d up=%b, want cnt=14 up=0", cnt, up);
        end
      end
      if (c == 31) begin
        vectors++;
        if (sweep_idx !== 4'd1 || cnt !== 4'd1 || up !== 1'b1) begin
          miscompares++;
          $display("FAIL full_sweep1: got idx=%0d cnt=%0d up=%b, want idx=1 cnt=1 up=1",
                   sweep_idx, cnt, up);
        end
      end
      if (done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || c != 61 || sweep_idx !== 4'd2 || cnt !== 4'd0) begin
      miscompares++;
      $display("FAIL full_done: got seen=%b cycles=%0d idx=%0d cnt=%0d, want seen=1 cycles=61 idx=2 cnt=0",
               seen, c, sweep_idx, cnt);
    end
    tick();
  endtask

  task automatic test_bad_start();
    logic [3:0] bad_lo [2] = '{4'd5, 4'd6};
    logic [3:0] bad_hi [2] = '{4'd5, 4'd3};
    for (int i = 0; i < 2; i++) begin
      lo = bad_lo[i]; hi = bad_hi[i]; nsweeps = 4'd1; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++;
      if (err !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_start%0d: got err=%b busy=%b, want err=1 busy=0", i, err, busy);
      end
      tick();
      vectors++;
      if (err !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL bad_start%0d_clear: got err=%b busy=%b, want err=0 busy=0", i, err, busy);
      end
    end
  endtask

  task automatic test_hold_and_ignored_start();
    int c    = 0;
    bit seen = 1'b0;
    bit erred = 1'b0;
    lo = 4'd1; hi = 4'd4; nsweeps = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      c++;
    end
    vectors++;
    if (cnt !== 4'd3 || up !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_entry: got cnt=%0d up=%b, want cnt=3 up=0", cnt, up);
    end
    hold = 1'b1;
    start = 1'b1; lo = 4'd0; hi = 4'd9;  // ignored while busy
    for (int i = 0; i < 3; i++) begin
      tick();
      c++;
      vectors++;
      if (cnt !== 4'd3 || up !== 1'b0 || err !== 1'b0 || sweep_idx !== 4'd0) begin
        miscompares++;
        $display("FAIL hold_frozen%0d: got cnt=%0d up=%b err=%b idx=%0d, want cnt=3 up=0 err=0 idx=0",
                 i, cnt, up, err, sweep_idx);
      end
    end
    hold = 1'b0;
    while (!seen && c < 60) begin
      tick();
      c++;
      if (err === 1'b1) erred = 1'b1;
      if (c == 12) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    vectors++;
    if (!seen || c != 22 || sweep_idx !== 4'd3 || cnt !== 4'd1 || erred) begin
      miscompares++;
      $display("FAIL hold_done: got seen=%b cycles=%0d idx=%0d cnt=%0d err_seen=%b, want seen=1 cycles=22 idx=3 cnt=1 err_seen=0",
               seen, c, sweep_idx, cnt, erred);
    end
    tick();
  endtask

  task automatic test_abort();
    lo = 4'd2; hi = 4'd6; nsweeps = 4'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (cnt !== 4'd4 || up !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre: got cnt=%0d up=%b, want cnt=4 up=1", cnt, up);
    end
    abort = 1'b1;
    hold  = 1'b1;  // abort must win over hold
    tick();
    abort = 1'b0;
    hold  = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || cnt !== 4'd4 || up !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_edge: got busy=%b done=%b cnt=%0d up=%b, want busy=0 done=0 cnt=4 up=0",
               busy, done, cnt, up);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0 || cnt !== 4'd4) begin
        miscompares++;
        $display("FAIL abort_idle%0d: got busy=%b done=%b cnt=%0d, want busy=0 done=0 cnt=4",
                 i, busy, done, cnt);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    lo = 4'd1; hi = 4'd5; nsweeps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    vectors++;
    if (cnt !== 4'd3 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got cnt=%0d busy=%b, want cnt=3 busy=1", cnt, busy);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({cnt, up, busy, done, err, sweep_idx} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid: got cnt=%0d up=%b busy=%b done=%b err=%b idx=%0d, want all 0",
               cnt, up, busy, done, err, sweep_idx);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_zero_sweeps();
`ifdef SWEEP_CONT_EN
    bit done_seen = 1'b0;
    lo = 4'd0; hi = 4'd1; nsweeps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 41; c++) begin
      tick();
      if (done === 1'b1) done_seen = 1'b1;
      if (c == 31 || c == 33 || c == 41) begin
        vectors++;
        if (sweep_idx !== 4'(((c - 1) / 2) % 16) || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL cont_idx_c%0d: got idx=%0d busy=%b, want idx=%0d busy=1",
                   c, sweep_idx, busy, ((c - 1) / 2) % 16);
        end
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || done_seen || done !== 1'b0) begin
      miscompares++;
      $display("FAIL cont_abort: got busy=%b done_seen=%b, want busy=0 done_seen=0", busy, done_seen);
    end
`else
    lo = 4'd1; hi = 4'd3; nsweeps = 4'd0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_sweeps: got err=%b busy=%b, want err=1 busy=0", err, busy);
    end
    tick();
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_sweeps_clear: got err=%b busy=%b, want err=0 busy=0", err, busy);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0;
    lo = '0; hi = '0; nsweeps = '0;
    test_reset();
    test_basic_sweep();
    test_full_range();
    test_bad_start();
    test_hold_and_ignored_start();
    test_abort();
    test_reset_mid_run();
    test_zero_sweeps();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
